div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative RV64M/RV32M divide/remainder unit: one quotient bit per cycle (radix-2 restoring).
- Sits beside the combinational ALU in EXU; EXU is the initiator, this block is the responder.
- Covers DIV/DIVU/REM/REMU plus the W variants; valid/ready handshake on both request and response.

Parameters:
- XLEN, 64, datapath width (32 or 64); defaults to the global `XLEN.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept request
- op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- word  in  1  W variant: operate on low 32 bits, sign-extend result; ignored when XLEN==32
- a  in  XLEN  dividend
- b  in  XLEN  divisor
- flush  in  1  abort current operation (pipeline redirect)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  XLEN  quotient or remainder per op
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n low): state IDLE; in_ready=1, out_valid=0, busy=0, result=0, counter=0.
- States: IDLE -> CALC -> DONE -> IDLE. in_ready = (state==IDLE).
- Accept: rising edge with in_valid && in_ready latches op, word, operands; N = 32 if word (XLEN==64) else XLEN.
- Signed ops divide magnitudes; quotient is negated if sign(a)!=sign(b), remainder takes the sign of a.
- Normal path: accept edge is edge 0; CALC runs cycles 1..N, one bit per cycle; edge N applies sign fix-up and enters DONE.
  - out_valid high from cycle N+1: 65 for XLEN=64, 33 for W ops.
- Special cases bypass CALC; IDLE -> DONE, out_valid in cycle 1.
  - b==0 (low 32 bits if word): quotient = all ones, remainder = a.
  - Signed overflow, a==most-negative and b==-1: quotient = a, remainder = 0.
- W ops: result = sign-extend(res[31:0]) for all four ops, including DIVUW/REMUW.
- DONE: result and out_valid held stable until out_ready. Handshake edge -> IDLE, out_valid=0.
  - No new request accepted in that same cycle; in_ready rises the following cycle.
- flush: priority over everything. Any state -> IDLE next edge, out_valid=0, result discarded.
  - flush concurrent with in_valid in IDLE: request not accepted.
- result register changes only at fix-up or special-case entry; no glitching during CALC.

Optional Feature:
- Macro DIV_REM_CACHE_EN.
- Defined:
  - Unit keeps the last normally completed a, b, word, signedness and both quotient and remainder.
  - A request matching all four (op quotient/remainder selection free) goes IDLE -> DONE with out_valid in cycle 1.
  - Serves DIV followed by REM on the same operands.
  - Cache is updated only on normal CALC completion, not on special cases or flushed operations; reset clears its valid bit.
- Undefined: no cache storage; every request takes full latency.

Decomposition:
- Shared header with the op encodings DIV_OP_DIV/DIVU/REM/REMU (2 bits), state encodings, and the W-op count 32, alongside the global `XLEN.
- One natural sub-module, div_core: shift/subtract iteration, counter, partial remainder and quotient registers.
- div_unit owns handshake, special-case detection, sign pre/post processing and the optional cache.

Test Plan:
- DIV a=-7, b=2 -> result 0xFFFFFFFFFFFFFFFD, out_valid at cycle 65; REM on same operands -> 0xFFFFFFFFFFFFFFFF (cycle 1 if DIV_REM_CACHE_EN).
- DIVU a=5, b=0 -> 0xFFFFFFFFFFFFFFFF; REMU -> 5; both with out_valid in cycle 1.
- DIV a=0x8000000000000000, b=-1 -> 0x8000000000000000; REM -> 0; cycle 1.
- DIVW a=0x12345678FFFFFFF9, b=2 -> 0xFFFFFFFFFFFFFFFD at cycle 33; REMUW a=0x00000000FFFFFFFF, b=0x10 -> 0x000000000000000F.
- Result ready, out_ready held low 10 cycles -> result stable, in_ready=0; out_ready=1 -> IDLE next edge, in_ready=1 one cycle later.
- flush in CALC cycle 10 -> IDLE next edge, out_valid never asserts; next request DIVU 100/7 -> 14 correct.

Source files
------------

// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg: shared definitions for the iterative divide/remainder unit.
//   - op encodings (DIV/DIVU/REM/REMU)
//   - controller state encoding
//   - bit count of the RV64 W-variant operations
// Provides a default for the global `XLEN macro when the build does not set it.
// -----------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 64
`endif

package div_pkg;

   localparam logic [1:0] DIV_OP_DIV  = 2'b00;
   localparam logic [1:0] DIV_OP_DIVU = 2'b01;
   localparam logic [1:0] DIV_OP_REM  = 2'b10;
   localparam logic [1:0] DIV_OP_REMU = 2'b11;

   // Width of the operands of the W-variant ops (DIVW, DIVUW, REMW, REMUW).
   localparam int DIV_W_BITS = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/div_core.sv
// -----------------------------------------------------------------------------
// div_core: radix-2 restoring divide datapath, one quotient bit per cycle.
// Operates on unsigned magnitudes. The dividend must be left-aligned so its
// most significant meaningful bit sits at XLEN-1 (the caller pre-shifts
// 32-bit operands); after n_iter steps quo holds the quotient and rem the
// remainder.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               load operands, clear partial remainder and counter
//   run                 perform one iteration this cycle
//   n_iter              number of iterations for this operation
//   dividend, divisor   unsigned magnitudes
//   last                high in the cycle that performs the final iteration
//   quo_nxt, rem_nxt    quotient / remainder after this cycle's iteration
// -----------------------------------------------------------------------------
module div_core
   import div_pkg::*;
#(
   parameter  int XLEN  = `XLEN,
   localparam int CNT_W = $clog2(XLEN + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             run,
   input  logic [CNT_W-1:0] n_iter,
   input  logic [XLEN-1:0]  dividend,
   input  logic [XLEN-1:0]  divisor,
   output logic             last,
   output logic [XLEN-1:0]  quo_nxt,
   output logic [XLEN-1:0]  rem_nxt
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] n_q, n_d;
   logic [XLEN-1:0]  rem_q, rem_d;
   logic [XLEN-1:0]  quo_q, quo_d;
   logic [XLEN-1:0]  div_q, div_d;

   logic [XLEN:0]    shifted;
   logic [XLEN-1:0]  trial;
   logic             ge;

   always_comb begin
      // Shift the next dividend bit into the partial remainder and try to
      // subtract. The partial remainder is always below the divisor, so the
      // difference fits in XLEN bits whenever the subtraction succeeds.
      shifted = {rem_q, quo_q[XLEN-1]};
      ge      = (shifted >= {1'b0, div_q});
      trial   = shifted[XLEN-1:0] - div_q;
      rem_nxt = ge ? trial : shifted[XLEN-1:0];
      quo_nxt = {quo_q[XLEN-2:0], ge};
      last    = run && (cnt_q == (n_q - CNT_W'(1)));

      cnt_d = cnt_q;
      n_d   = n_q;
      rem_d = rem_q;
      quo_d = quo_q;
      div_d = div_q;
      if (start) begin
         cnt_d = '0;
         n_d   = n_iter;
         rem_d = '0;
         quo_d = dividend;
         div_d = divisor;
      end else if (run) begin
         cnt_d = cnt_q + CNT_W'(1);
         rem_d = rem_nxt;
         quo_d = quo_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         n_q   <= '0;
      end else begin
         cnt_q <= cnt_d;
         n_q   <= n_d;
      end
   end

   // Datapath registers are always loaded before use, so they carry no reset.
   always_ff @(posedge clk) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      div_q <= div_d;
   end

endmodule

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit: iterative RV64M/RV32M DIV/DIVU/REM/REMU (+ W variants).
// Handshake, special-case detection (divide by zero, signed overflow), sign
// pre/post processing and an optional last-result cache around div_core.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake (in_ready only in IDLE)
//   op                    00 DIV, 01 DIVU, 10 REM, 11 REMU
//   word                  W variant (low 32 bits, sign-extended result);
//                         ignored when XLEN == 32
//   a, b                  dividend, divisor
//   flush                 abort: back to IDLE on the next edge, highest priority
//   out_valid / out_ready response handshake; result held until accepted
//   result                quotient or remainder
//   busy                  unit not in IDLE
//
// Build option: define DIV_REM_CACHE_EN to keep the quotient and remainder of
// the last normally completed operation, so a matching request (e.g. REM
// after DIV on the same operands) completes in one cycle.
// -----------------------------------------------------------------------------
module div_unit
   import div_pkg::*;
#(
   parameter int XLEN = `XLEN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      op,
   input  logic            word,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   localparam int CNT_W = $clog2(XLEN + 1);

   // Sign- or zero-extend the low 32 bits to the full width.
   function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] v,
                                             input logic sx);
      logic [XLEN-1:0] r;
      r = v;
      for (int i = DIV_W_BITS; i < XLEN; i++) r[i] = sx & v[DIV_W_BITS-1];
      return r;
   endfunction

   function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
      return XLEN'(-$signed(v));
   endfunction

   // Final result formatting: W ops always sign-extend bit 31.
   function automatic logic [XLEN-1:0] fin(input logic [XLEN-1:0] v,
                                           input logic w);
      return w ? ext32(v, 1'b1) : v;
   endfunction

   div_state_e      state_q, state_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            rem_q, rem_d;
   logic            w_q, w_d;
   logic            qneg_q, qneg_d;
   logic            rneg_q, rneg_d;

   logic            sgn_in, rem_in, w_in;
   logic [XLEN-1:0] a_e, b_e, min_neg, mag_a, mag_b;
   logic            a_neg, b_neg, b_zero, ovf;
   logic [XLEN-1:0] dividend;
   logic [CNT_W-1:0] n_iter;
   logic            start, run, last;
   logic [XLEN-1:0] quo_nxt, rem_nxt, q_fin, r_fin;
   logic            hit;
   logic [XLEN-1:0] hit_res;

`ifdef DIV_REM_CACHE_EN
   logic            cv_q, cv_d;
   logic [XLEN-1:0] c_a_q, c_a_d, c_b_q, c_b_d;
   logic            c_w_q, c_w_d, c_s_q, c_s_d;
   logic [XLEN-1:0] c_quo_q, c_quo_d, c_rem_q, c_rem_d;
   // Operands of the operation in flight, committed to the cache on completion.
   logic [XLEN-1:0] p_a_q, p_a_d, p_b_q, p_b_d;
   logic            p_s_q, p_s_d;
`endif

   always_comb begin
      // Request decode and operand conditioning
      sgn_in  = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
      rem_in  = (op == DIV_OP_REM) || (op == DIV_OP_REMU);
      w_in    = (XLEN == 64) && word;
      a_e     = w_in ? ext32(a, sgn_in) : a;
      b_e     = w_in ? ext32(b, sgn_in) : b;
      a_neg   = sgn_in && ($signed(a_e) < 0);
      b_neg   = sgn_in && ($signed(b_e) < 0);
      // Most negative value of the effective width, already extended.
      min_neg = '1 << (w_in ? DIV_W_BITS - 1 : XLEN - 1);
      b_zero  = (b_e == '0);
      ovf     = sgn_in && (a_e == min_neg) && (b_e == '1);
      mag_a   = a_neg ? negate(a_e) : a_e;
      mag_b   = b_neg ? negate(b_e) : b_e;
      // Left-align 32-bit dividends so the core always consumes from the MSB.
      dividend = w_in ? (mag_a << (XLEN - DIV_W_BITS)) : mag_a;
      n_iter   = w_in ? CNT_W'(DIV_W_BITS) : CNT_W'(XLEN);

      // Sign fix-up of the core's final step
      q_fin = fin(qneg_q ? negate(quo_nxt) : quo_nxt, w_q);
      r_fin = fin(rneg_q ? negate(rem_nxt) : rem_nxt, w_q);

      hit     = 1'b0;
      hit_res = '0;
`ifdef DIV_REM_CACHE_EN
      hit     = cv_q && (c_a_q == a_e) && (c_b_q == b_e) &&
                (c_w_q == w_in) && (c_s_q == sgn_in);
      hit_res = rem_in ? c_rem_q : c_quo_q;
      cv_d    = cv_q;
      c_a_d   = c_a_q;
      c_b_d   = c_b_q;
      c_w_d   = c_w_q;
      c_s_d   = c_s_q;
      c_quo_d = c_quo_q;
      c_rem_d = c_rem_q;
      p_a_d   = p_a_q;
      p_b_d   = p_b_q;
      p_s_d   = p_s_q;
`endif

      state_d  = state_q;
      result_d = result_q;
      rem_d    = rem_q;
      w_d      = w_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      start    = 1'b0;

      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  rem_d  = rem_in;
                  w_d    = w_in;
                  qneg_d = a_neg ^ b_neg;
                  rneg_d = a_neg;
                  if (b_zero) begin
                     result_d = fin(rem_in ? a_e : '1, w_in);
                     state_d  = ST_DONE;
                  end else if (ovf) begin
                     result_d = fin(rem_in ? '0 : a_e, w_in);
                     state_d  = ST_DONE;
                  end else if (hit) begin
                     result_d = hit_res;
                     state_d  = ST_DONE;
                  end else begin
                     start   = 1'b1;
                     state_d = ST_CALC;
`ifdef DIV_REM_CACHE_EN
                     p_a_d = a_e;
                     p_b_d = b_e;
                     p_s_d = sgn_in;
`endif
                  end
               end
            end
            ST_CALC: begin
               if (last) begin
                  result_d = rem_q ? r_fin : q_fin;
                  state_d  = ST_DONE;
`ifdef DIV_REM_CACHE_EN
                  cv_d    = 1'b1;
                  c_a_d   = p_a_q;
                  c_b_d   = p_b_q;
                  c_w_d   = w_q;
                  c_s_d   = p_s_q;
                  c_quo_d = q_fin;
                  c_rem_d = r_fin;
`endif
               end
            end
            ST_DONE: begin
               if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end

      run       = (state_q == ST_CALC);
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
      busy      = (state_q != ST_IDLE);
      result    = result_q;
   end

   div_core #(.XLEN(XLEN)) u_core (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .run      (run),
      .n_iter   (n_iter),
      .dividend (dividend),
      .divisor  (mag_b),
      .last     (last),
      .quo_nxt  (quo_nxt),
      .rem_nxt  (rem_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
         rem_q    <= 1'b0;
         w_q      <= 1'b0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         rem_q    <= rem_d;
         w_q      <= w_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
      end
   end

`ifdef DIV_REM_CACHE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cv_q <= 1'b0;
      end else begin
         cv_q <= cv_d;
      end
   end

   // Cache payload is qualified by cv_q and needs no reset.
   always_ff @(posedge clk) begin
      c_a_q   <= c_a_d;
      c_b_q   <= c_b_d;
      c_w_q   <= c_w_d;
      c_s_q   <= c_s_d;
      c_quo_q <= c_quo_d;
      c_rem_q <= c_rem_d;
      p_a_q   <= p_a_d;
      p_b_q   <= p_b_d;
      p_s_q   <= p_s_d;
   end
`endif

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;
   localparam logic [63:0] MIN64  = 64'h8000_0000_0000_0000;
   localparam int TIMEOUT = 200;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  op;
   logic        word;
   logic [63:0] a;
   logic [63:0] b;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] result;
   logic        busy;

   int checks = 0;
   int errors = 0;

   // Last normally completed operation (cache model).
   logic        key_v = 1'b0;
   logic [63:0] key_a, key_b;
   logic        key_w, key_s;

   div_unit #(.XLEN(64)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .word      (word),
      .a         (a),
      .b         (b),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%016h exp 0x%016h", tag, got, exp);
      end
   endtask

   // Reference: RISC-V M semantics with plain integer arithmetic.
   function automatic logic [63:0] ref_model(input logic [1:0] o, input logic w,
                                             input logic [63:0] x,
                                             input logic [63:0] y);
      logic sgn, rem;
      logic [31:0] r32;
      int sx, sy;
      int unsigned ux, uy;
      longint lx, ly;
      longint unsigned vx, vy;
      sgn = (o == OP_DIV) || (o == OP_REM);
      rem = o[1];
      if (w) begin
         sx = x[31:0]; sy = y[31:0]; ux = x[31:0]; uy = y[31:0];
         if (uy == 0)                                  r32 = rem ? x[31:0] : 32'hFFFF_FFFF;
         else if (sgn && sx == 32'sh8000_0000 && sy == -1) r32 = rem ? 32'd0 : x[31:0];
         else if (sgn)                                 r32 = rem ? sx % sy : sx / sy;
         else                                          r32 = rem ? ux % uy : ux / uy;
         return {{32{r32[31]}}, r32};
      end
      lx = x; ly = y; vx = x; vy = y;
      if (vy == 0)                               return rem ? x : 64'hFFFF_FFFF_FFFF_FFFF;
      if (sgn && x == MIN64 && ly == -1)         return rem ? 64'd0 : x;
      if (sgn)                                   return rem ? lx % ly : lx / ly;
      return rem ? vx % vy : vx / vy;
   endfunction

   function automatic logic [63:0] eff(input logic [63:0] x, input logic w);
      return w ? {32'd0, x[31:0]} : x;
   endfunction

   function automatic logic is_special(input logic [1:0] o, input logic w,
                                       input logic [63:0] x, input logic [63:0] y);
      logic sgn;
      sgn = (o == OP_DIV) || (o == OP_REM);
      if (eff(y, w) == 0) return 1'b1;
      if (!sgn) return 1'b0;
      if (w) return (x[31:0] == 32'h8000_0000) && (y[31:0] == 32'hFFFF_FFFF);
      return (x == MIN64) && (y == 64'hFFFF_FFFF_FFFF_FFFF);
   endfunction

   function automatic logic cache_hit(input logic [1:0] o, input logic w,
                                      input logic [63:0] x, input logic [63:0] y);
      logic sgn;
      sgn = (o == OP_DIV) || (o == OP_REM);
`ifdef DIV_REM_CACHE_EN
      return key_v && key_a == eff(x, w) && key_b == eff(y, w) &&
             key_w == w && key_s == sgn;
`else
      return 1'b0;
`endif
   endfunction

   task automatic run_op(input string tag, input logic [1:0] o, input logic w,
                         input logic [63:0] x, input logic [63:0] y,
                         input int hold);
      logic [63:0] exp;
      int exp_lat, lat;
      logic sp, hit;
      exp = ref_model(o, w, x, y);
      sp  = is_special(o, w, x, y);
      hit = cache_hit(o, w, x, y);
      exp_lat = (sp || hit) ? 1 : (w ? 33 : 65);
      @(negedge clk);
      check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      op = o; word = w; a = x; b = y; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      @(negedge clk);
      lat = 1;
      while (!out_valid && lat < TIMEOUT) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      check({tag, "_result"}, result, exp);
      check({tag, "_busy"}, 64'(busy), 64'd1);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, "_hold_result"}, result, exp);
         check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
         check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, "_post_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_post_in_ready"}, 64'(in_ready), 64'd1);
      if (!sp && !hit) begin
         key_v = 1'b1;
         key_a = eff(x, w);
         key_b = eff(y, w);
         key_w = w;
         key_s = (o == OP_DIV) || (o == OP_REM);
      end
   endtask

   function automatic logic [63:0] rnd_operand(input int kind);
      logic [63:0] v;
      case (kind)
         0: v = 64'd0;
         1: v = 64'hFFFF_FFFF_FFFF_FFFF;
         2: v = MIN64;
         3: v = 64'hFFFF_FFFF_8000_0000;
         4, 5: begin
            v = 64'($urandom_range(1, 1000));
            if ($urandom_range(0, 1) == 1) v = -v;
         end
         6: v = {32'd0, $urandom()};
         default: v = {$urandom(), $urandom()};
      endcase
      return v;
   endfunction

   initial begin
      logic seen;
      logic [1:0] ro;
      logic rw;
      logic [63:0] ra, rb;
      rst_n = 1'b0; in_valid = 1'b0; op = 2'b00; word = 1'b0;
      a = '0; b = '0; flush = 1'b0; out_ready = 1'b0;
      #12;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_result", result, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("div_m7_2", OP_DIV, 1'b0, -64'sd7, 64'd2, 0);
      run_op("rem_m7_2", OP_REM, 1'b0, -64'sd7, 64'd2, 0);
      run_op("divu_by0", OP_DIVU, 1'b0, 64'd5, 64'd0, 0);
      run_op("remu_by0", OP_REMU, 1'b0, 64'd5, 64'd0, 0);
      run_op("div_ovf", OP_DIV, 1'b0, MIN64, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      run_op("rem_ovf", OP_REM, 1'b0, MIN64, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      run_op("divw", OP_DIV, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 0);
      run_op("remuw", OP_REMU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h10, 0);
      run_op("divuw_sext", OP_DIVU, 1'b1, 64'hAAAA_0000_FFFF_FFF0, 64'd1, 0);
      run_op("hold10", OP_DIVU, 1'b0, 64'd1000, 64'd9, 10);

      // Flush during CALC cycle 10
      @(negedge clk);
      op = OP_DIV; word = 1'b0; a = 64'd1000003; b = 64'd3; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush_out_valid", 64'(out_valid), 64'd0);
      check("flush_busy", 64'(busy), 64'd0);
      check("flush_in_ready", 64'(in_ready), 64'd1);
      seen = 1'b0;
      repeat (80) begin
         @(negedge clk);
         seen = seen | out_valid;
      end
      check("flush_never_valid", 64'(seen), 64'd0);

      // Flush concurrent with a request in IDLE
      @(negedge clk);
      op = OP_DIVU; word = 1'b0; a = 64'd77; b = 64'd0; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0; flush = 1'b0;
      check("flush_idle_busy", 64'(busy), 64'd0);
      @(negedge clk);
      check("flush_idle_valid", 64'(out_valid), 64'd0);

      run_op("divu_100_7", OP_DIVU, 1'b0, 64'd100, 64'd7, 0);

      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom_range(0, 3));
         rw = 1'($urandom_range(0, 1));
         if (i > 0 && $urandom_range(0, 3) == 0) begin
            ro = {~ro[1], ro[0]};
         end else begin
            ra = rnd_operand($urandom_range(0, 9));
            rb = rnd_operand($urandom_range(0, 9));
         end
         run_op($sformatf("rnd%0d", i), ro, rw, ra, rb, $urandom_range(0, 2));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
